// File: rtl/io_pkg.sv
// Shared types and constants for the IN/OUT handshake controller.
// Holds the FSM state encoding and the bus/switch/PWM widths.
package io_pkg;

    localparam int DATA_W = 32;
    localparam int SW_W   = 8;
    localparam int PWM_W  = 8;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ARM        = 3'd1,
        WAIT_PRESS = 3'd2,
        WAIT_REL   = 3'd3,
        ACK        = 3'd4
    } io_state_t;

endpackage

// File: rtl/key_debouncer.sv
// Push-button conditioning: 2-FF synchronizer, stability counter and debounced level.
// Ports: clk, rst_n, key_raw (active-low) in; key_deb level, press_evt/rel_evt pulses out.
module key_debouncer #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_deb,
    output logic press_evt,
    output logic rel_evt
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;

    // Events are registered alongside the level so they line up with it.
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        deb_d   = deb_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            deb_d   = sync2_q;
            press_d = ~sync2_q;
            rel_d   = sync2_q;
        end
    end

    // Reset values model a released (high) key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            deb_q   <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign key_deb   = deb_q;
    assign press_evt = press_q;
    assign rel_evt   = rel_q;

endmodule

// File: rtl/io_handshake_ctrl.sv
// Sequences CPU IN (key-gated switch read) and OUT (display/PWM latch) instructions.
// Ports: realClk, rst, chave, dadosIN, in_req/in_data/in_ack/stall, out_req/out_pwm/out_data, disp/pwm/st_dbg.
module io_handshake_ctrl
    import io_pkg::*;
#(
    parameter int DEB_CYCLES = 50000,
    parameter int DATA_W     = io_pkg::DATA_W,
    parameter int SW_W       = io_pkg::SW_W
) (
    input  logic              realClk,
    input  logic              rst,
    input  logic              chave,
    input  logic [SW_W-1:0]   dadosIN,
    input  logic              in_req,
    output logic [DATA_W-1:0] in_data,
    output logic              in_ack,
    output logic              stall,
    input  logic              out_req,
    input  logic              out_pwm,
    input  logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] disp_value,
    output logic              disp_valid,
    output logic [PWM_W-1:0]  pwm_duty,
    output logic [2:0]        st_dbg
);

    logic key_deb, press_evt, rel_evt;

    key_debouncer #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
        .clk       (realClk),
        .rst_n     (rst),
        .key_raw   (chave),
        .key_deb   (key_deb),
        .press_evt (press_evt),
        .rel_evt   (rel_evt)
    );

    io_state_t         state_q, state_d;
    logic [DATA_W-1:0] in_data_q, in_data_d;
    logic              in_ack_q, in_ack_d;
    logic [DATA_W-1:0] disp_q, disp_d;
    logic              valid_q, valid_d;
    logic [PWM_W-1:0]  pwm_q, pwm_d;

    // Dropping in_req in any waiting state abandons the IN without ack.
    always_comb begin
        state_d   = state_q;
        in_data_d = in_data_q;
        unique case (state_q)
            IDLE: begin
                if (in_req) state_d = ARM;
            end
            ARM: begin
                // Wait for release so a key held from a prior IN is not reused.
                if (!in_req)      state_d = IDLE;
                else if (key_deb) state_d = WAIT_PRESS;
            end
            WAIT_PRESS: begin
                if (!in_req) begin
                    state_d = IDLE;
                end else if (press_evt) begin
                    in_data_d = {{(DATA_W-SW_W){1'b0}}, dadosIN};
                    state_d   = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!in_req)      state_d = IDLE;
                else if (rel_evt) state_d = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        in_ack_d = (state_d == ACK);
    end

    always_comb begin
        pwm_d   = pwm_q;
        disp_d  = disp_q;
        valid_d = valid_q;
        if (out_req) begin
            if (out_pwm) begin
                pwm_d = out_data[PWM_W-1:0];
            end else begin
                disp_d  = out_data;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge realClk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            in_data_q <= '0;
            in_ack_q  <= 1'b0;
            disp_q    <= '0;
            valid_q   <= 1'b0;
            pwm_q     <= '0;
        end else begin
            state_q   <= state_d;
            in_data_q <= in_data_d;
            in_ack_q  <= in_ack_d;
            disp_q    <= disp_d;
            valid_q   <= valid_d;
            pwm_q     <= pwm_d;
        end
    end

    // Gated by rst so every output reads zero while reset is held.
    assign stall      = rst & in_req & (state_q != ACK);
    assign in_data    = in_data_q;
    assign in_ack     = in_ack_q;
    assign disp_value = disp_q;
    assign disp_valid = valid_q;
    assign pwm_duty   = pwm_q;
    assign st_dbg     = state_q;

endmodule

// File: doc/io_handshake_ctrl.md
Name: io_handshake_ctrl

Overview:
- Sequences the processor's IN/OUT instructions against board I/O.
- On IN: stalls the CPU, waits for a debounced press-and-release of the key, then returns the switch value (zero-extended) with a one-cycle ack.
- On OUT: latches the CPU bus into either the display-value register or the PWM-duty register.
- Sits between the processor and the output module, replacing ad-hoc key sampling.

Parameters:
- DEB_CYCLES, 50000, stable cycles required before the debounced key changes (1 ms at 50 MHz).
- DATA_W, 32, CPU bus width.
- SW_W, 8, switch width.

Ports:
- realClk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- chave  in  1  raw push-button, active-low (0 = pressed); asynchronous to realClk.
- dadosIN  in  SW_W  switch inputs; treated as quasi-static.
- in_req  in  1  CPU IN instruction pending; level, held until in_ack.
- in_data  out  DATA_W  captured input value.
- in_ack  out  1  one-cycle pulse: in_data valid.
- stall  out  1  CPU hold request.
- out_req  in  1  CPU OUT write strobe; one-cycle pulse.
- out_pwm  in  1  OUT target select: 1 = PWM duty, 0 = display.
- out_data  in  DATA_W  CPU output bus.
- disp_value  out  DATA_W  value shown on the displays.
- disp_valid  out  1  high once any display write has occurred.
- pwm_duty  out  8  PWM duty, taken from out_data[7:0].
- st_dbg  out  3  current FSM state encoding.

Behaviour:
Reset (rst=0, async):
- All outputs go to 0; FSM goes to IDLE.
- Debounced key is forced to released; debounce counter is cleared.

Key conditioning:
- chave passes through a 2-FF synchronizer.
- Counter clears whenever the synchronized value equals the debounced value; otherwise it increments.
- When the counter reaches DEB_CYCLES-1, the debounced value takes the synchronized value and the counter clears.
- press_evt / rel_evt are single-cycle pulses on debounced falling / rising edges.

FSM states: IDLE, ARM, WAIT_PRESS, WAIT_REL, ACK.
- IDLE: if in_req, go to ARM.
- ARM: if debounced key is released, go to WAIT_PRESS. This guarantees a fresh press, so a key held from a previous IN is not reused.
- WAIT_PRESS: on press_evt, capture in_data <= {zeros, dadosIN} in the same cycle and go to WAIT_REL.
- WAIT_REL: on rel_evt, go to ACK.
- ACK: in_ack = 1 for exactly this cycle; next state is IDLE.
- stall = in_req && state != ACK, combinational, so the CPU is held from the first in_req cycle.
- Minimum latency: 2·DEB_CYCLES + 4 cycles from in_req to in_ack after the raw key toggles.
- in_req deasserted in ARM/WAIT_PRESS/WAIT_REL: return to IDLE next cycle, no ack; in_data keeps its last value.
- in_req still high in the cycle after ACK: treated as a new request (IDLE→ARM).

OUT path (independent of the FSM, same cycle):
- On out_req with out_pwm=1: pwm_duty <= out_data[7:0]; upper bits are ignored.
- On out_req with out_pwm=0: disp_value <= out_data and disp_valid <= 1.
- Registers update on the clock edge where out_req is high and hold otherwise.
- out_req during a pending IN is honoured; there is no arbitration conflict.

Reset mid-operation:
- All of the above is aborted immediately; no spurious in_ack after reset release.

Decomposition:
- Shared package io_pkg holds:
  - io_state_t enum (IDLE=0, ARM=1, WAIT_PRESS=2, WAIT_REL=3, ACK=4);
  - DATA_W and SW_W constants;
  - PWM_W = 8.
- Sub-module key_debouncer contains the synchronizer, counter, debounced level and press_evt/rel_evt outputs; parameter DEB_CYCLES.
- FSM and OUT registers live in io_handshake_ctrl.

Test Plan (DEB_CYCLES=4):
- Reset check: assert rst=0 mid-run → all outputs 0 and st_dbg=0 asynchronously; release → no in_ack for 20 cycles.
- Clean IN: dadosIN=8'hA5, in_req=1, key pressed 10 cycles then released → stall high throughout; one in_ack pulse; in_data=32'h000000A5; stall low on the ack cycle.
- Bounce rejection: chave toggles every 2 cycles for 12 cycles, then settles low → exactly one press_evt; in_data captured once after settling.
- Held key: key already pressed when in_req rises → no capture until release + new press; dadosIN=8'h3C at the second press → in_data=32'h3C.
- OUT writes: out_req with out_pwm=1, out_data=32'h1234_5680 → pwm_duty=8'h80, disp unchanged; then out_pwm=0, out_data=32'd999 → disp_value=999, disp_valid=1; both issued during WAIT_PRESS → FSM unaffected.
- Abort: in_req drops in WAIT_REL → IDLE next cycle, no in_ack, in_data retains the captured value.
